// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-system types.
//   word_t      : 32-bit data/address word
//   ramstate_t  : RAM model handshake state (FREE/BUSY/ACCESS/ERROR)
//   arb_state_t : ram_arbiter FSM state (IDLE/GRANT/RELEASE)
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;
endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the requesters, the RAM model and ram_arbiter.
//   Requester side : mode, req_ren/req_wen/req_addr/req_store in; req_wait/req_load out
//   RAM side       : ramREN/ramWEN/ramaddr/ramstore out; ramload/ramstate in
//   Status         : grant_valid, grant_id, timeout
// slave  = the arbiter's view, master = the environment's view.
interface ram_arbiter_if #(parameter int NREQ = 4);
   import cpu_types_pkg::*;

   logic                      mode;
   logic  [NREQ-1:0]          req_ren;
   logic  [NREQ-1:0]          req_wen;
   word_t [NREQ-1:0]          req_addr;   // requester i at [32i+31:32i]
   word_t [NREQ-1:0]          req_store;
   logic  [NREQ-1:0]          req_wait;
   word_t                     req_load;
   logic                      ramREN;
   logic                      ramWEN;
   word_t                     ramaddr;
   word_t                     ramstore;
   word_t                     ramload;
   ramstate_t                 ramstate;
   logic                      grant_valid;
   logic  [$clog2(NREQ)-1:0]  grant_id;
   logic                      timeout;

   modport slave (
      input  mode, req_ren, req_wen, req_addr, req_store, ramload, ramstate,
      output req_wait, req_load, ramREN, ramWEN, ramaddr, ramstore,
             grant_valid, grant_id, timeout
   );

   modport master (
      output mode, req_ren, req_wen, req_addr, req_store, ramload, ramstate,
      input  req_wait, req_load, ramREN, ramWEN, ramaddr, ramstore,
             grant_valid, grant_id, timeout
   );
endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// rr_pick: combinational winner selection for ram_arbiter.
//   i_req    : request vector
//   i_ptr    : index of last served requester (round-robin starts at i_ptr+1)
//   i_mode   : 0 = round-robin, 1 = fixed priority (lowest index wins)
//   o_winner : selected index (0 when nothing requests)
//   o_any    : at least one request present
module rr_pick #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         i_req,
   input  logic [$clog2(NREQ)-1:0] i_ptr,
   input  logic                    i_mode,
   output logic [$clog2(NREQ)-1:0] o_winner,
   output logic                    o_any
);
   localparam int IDXW = $clog2(NREQ);

   logic [IDXW-1:0] w_base;
   int              w_idx;
   logic            w_found;

   // Fixed priority is round-robin searched from a pointer parked at NREQ-1.
   assign w_base = i_mode ? IDXW'(NREQ-1) : i_ptr;
   assign o_any  = |i_req;

   always_comb begin
      o_winner = '0;
      w_found  = 1'b0;
      w_idx    = 0;
      for (int k = 1; k <= NREQ; k++) begin
         w_idx = (int'(w_base) + k) % NREQ;
         if (!w_found && i_req[w_idx]) begin
            o_winner = IDXW'(w_idx);
            w_found  = 1'b1;
         end
      end
   end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port among NREQ requesters, one transaction at
// a time, with round-robin or fixed-priority selection and a grant watchdog.
//   CLK : clock, rising edge
//   RST : asynchronous active-high reset
//   bus : ram_arbiter_if.slave (requester, RAM and status signals)
// Outputs in GRANT are combinational from the held grant so that ACCESS,
// abort and watchdog release all take effect in the same cycle.
module ram_arbiter
   import cpu_types_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 255
) (
   input  logic          CLK,
   input  logic          RST,
   ram_arbiter_if.slave  bus
);
   localparam int IDXW = $clog2(NREQ);
   localparam int WDW  = $clog2(TIMEOUT+1);

   arb_state_t      r_state;
   logic [IDXW-1:0] r_ptr;
   logic [IDXW-1:0] r_gnt;
   logic [WDW-1:0]  r_wdog;

   logic [NREQ-1:0] w_req;
   logic [IDXW-1:0] w_winner;
   logic            w_any;
   logic            w_grant;
   logic            w_gnt_req;
   logic            w_access;
   logic            w_abort;
   logic            w_tmo;

   assign w_req = bus.req_ren | bus.req_wen;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .i_req    (w_req),
      .i_ptr    (r_ptr),
      .i_mode   (bus.mode),
      .o_winner (w_winner),
      .o_any    (w_any)
   );

   assign w_grant   = (r_state == GRANT);
   assign w_gnt_req = w_req[r_gnt];
   // A dropped request wins over everything: the enables are already gone,
   // so a concurrent ACCESS cannot be reported as a completion.
   assign w_abort   = w_grant & ~w_gnt_req;
   assign w_access  = w_grant & w_gnt_req & (bus.ramstate == ACCESS);
   assign w_tmo     = w_grant & w_gnt_req & (bus.ramstate != ACCESS) &
                      (r_wdog == WDW'(TIMEOUT-1));

   always_comb begin
      bus.req_wait    = '1;
      bus.req_load    = '0;
      bus.ramREN      = 1'b0;
      bus.ramWEN      = 1'b0;
      bus.ramaddr     = '0;
      bus.ramstore    = '0;
      bus.grant_valid = 1'b0;
      bus.grant_id    = '0;
      bus.timeout     = w_tmo;
      if (w_grant) begin
         bus.ramaddr     = bus.req_addr[r_gnt];
         bus.ramstore    = bus.req_store[r_gnt];
         // write wins when both enables are set
         bus.ramWEN      = bus.req_wen[r_gnt];
         bus.ramREN      = bus.req_ren[r_gnt] & ~bus.req_wen[r_gnt];
         bus.grant_valid = 1'b1;
         bus.grant_id    = r_gnt;
      end
      if (w_access) begin
         bus.req_wait[r_gnt] = 1'b0;
         bus.req_load        = bus.ramload;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= IDLE;
         r_ptr   <= IDXW'(NREQ-1);
         r_gnt   <= '0;
         r_wdog  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_gnt   <= w_winner;
                  r_wdog  <= '0;
                  r_state <= GRANT;
               end
            end
            GRANT: begin
               if (w_abort) begin
                  r_state <= IDLE;            // pointer left alone on abort
               end else if (w_access || w_tmo) begin
                  r_ptr   <= r_gnt;
                  r_state <= RELEASE;
               end else if (r_wdog != '1) begin
                  r_wdog  <= r_wdog + WDW'(1);
               end
            end
            RELEASE: r_state <= IDLE;         // bubble so the requester can drop
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter (NREQ=4, TIMEOUT=4).
// Expected grants are queued when stimulus is applied and popped as the
// arbiter issues each grant.
module tb_ram_arbiter;
   import cpu_types_pkg::*;

   localparam int N = 4;

   typedef struct {
      int    id;
      word_t load;
   } exp_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t exp_q[$];

   always #5 CLK = ~CLK;

   ram_arbiter_if #(.NREQ(N)) bus ();

   ram_arbiter #(.NREQ(N), .TIMEOUT(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   // Waits (bounded) for the next negedge at which a grant is held.
   task automatic wait_grant(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (bus.grant_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      RST = 1'b1;
      bus.req_ren = '1;
      repeat (3) @(negedge CLK);
      n_vec++; if (bus.req_wait !== 4'hF) begin n_err++; $display("FAIL reset_wait: got %h want f", bus.req_wait); end
      n_vec++; if ({bus.ramREN, bus.ramWEN, bus.grant_valid, bus.timeout} !== 4'b0) begin n_err++;
         $display("FAIL reset_ctl: got %b want 0000", {bus.ramREN, bus.ramWEN, bus.grant_valid, bus.timeout}); end
      n_vec++; if ({bus.ramaddr, bus.ramstore, bus.req_load, bus.grant_id} !== '0) begin n_err++;
         $display("FAIL reset_data: addr %h store %h load %h id %0d want all 0", bus.ramaddr, bus.ramstore, bus.req_load, bus.grant_id); end
      bus.req_ren = '0;
      RST = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_single;
      exp_t e;
      logic [N-1:0] ew;
      exp_q.push_back('{1, 32'hDEADBEEF});
      bus.req_addr[1] = 32'h40;
      bus.ramload     = 32'hDEADBEEF;
      bus.ramstate    = BUSY;
      bus.req_ren[1]  = 1'b1;
      @(negedge CLK);                    // first GRANT cycle
      e = exp_q.pop_front();
      ew = '1; ew[e.id] = 1'b0;
      n_vec++; if ({bus.grant_valid, bus.grant_id} !== {1'b1, 2'(e.id)}) begin n_err++;
         $display("FAIL single_grant: got v%b id%0d want v1 id%0d", bus.grant_valid, bus.grant_id, e.id); end
      n_vec++; if ({bus.ramREN, bus.ramWEN, bus.ramaddr} !== {2'b10, 32'h40}) begin n_err++;
         $display("FAIL single_ram: got ren%b wen%b addr %h want ren1 wen0 addr 40", bus.ramREN, bus.ramWEN, bus.ramaddr); end
      n_vec++; if (bus.req_wait !== 4'hF) begin n_err++; $display("FAIL single_busy_wait: got %h want f", bus.req_wait); end
      @(negedge CLK);                    // second GRANT cycle
      bus.ramstate = ACCESS;
      #1;
      n_vec++; if (bus.req_wait !== ew) begin n_err++; $display("FAIL single_done_wait: got %h want %h", bus.req_wait, ew); end
      n_vec++; if (bus.req_load !== e.load) begin n_err++; $display("FAIL single_load: got %h want %h", bus.req_load, e.load); end
      @(negedge CLK);                    // RELEASE
      n_vec++; if ({bus.req_wait, bus.ramREN, bus.grant_valid, bus.req_load} !== {4'hF, 2'b00, 32'h0}) begin n_err++;
         $display("FAIL single_release: wait %h ren %b gv %b load %h want f 0 0 0", bus.req_wait, bus.ramREN, bus.grant_valid, bus.req_load); end
      bus.ramstate   = FREE;
      bus.req_ren[1] = 1'b0;
      @(negedge CLK);                    // IDLE
      n_vec++; if ({bus.grant_valid, bus.ramREN} !== 2'b00) begin n_err++;
         $display("FAIL single_idle: got gv%b ren%b want 00", bus.grant_valid, bus.ramREN); end
   endtask

   // Pointer sits at 1 after test_single, so requester 2 is searched first.
   task automatic test_write_arb;
      exp_t e;
      bit ok;
      logic [N-1:0] ew;
      exp_q.push_back('{2, 32'h0});
      exp_q.push_back('{3, 32'h5555AAAA});
      bus.req_addr[2]  = 32'h80;
      bus.req_store[2] = 32'h12345678;
      bus.req_addr[3]  = 32'hC0;
      bus.req_wen[2]   = 1'b1;
      bus.req_ren[3]   = 1'b1;
      for (int n = 0; n < 2; n++) begin
         wait_grant(ok);
         e = exp_q.pop_front();
         ew = '1; ew[e.id] = 1'b0;
         n_vec++; if (!ok) begin n_err++; $display("FAIL wr_grant_wait: no grant, want id %0d", e.id); end
         n_vec++; if (bus.grant_id !== 2'(e.id)) begin n_err++; $display("FAIL wr_grant_id: got %0d want %0d", bus.grant_id, e.id); end
         if (e.id == 2) begin
            n_vec++; if ({bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore} !== {2'b10, 32'h80, 32'h12345678}) begin n_err++;
               $display("FAIL wr_write: got wen%b ren%b addr %h store %h want 1 0 80 12345678", bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore); end
         end else begin
            n_vec++; if ({bus.ramWEN, bus.ramREN, bus.ramaddr} !== {2'b01, 32'hC0}) begin n_err++;
               $display("FAIL wr_read3: got wen%b ren%b addr %h want 0 1 c0", bus.ramWEN, bus.ramREN, bus.ramaddr); end
         end
         bus.ramload  = e.load;
         bus.ramstate = ACCESS;
         #1;
         n_vec++; if (bus.req_wait !== ew) begin n_err++; $display("FAIL wr_done_wait: got %h want %h", bus.req_wait, ew); end
         @(negedge CLK);
         bus.ramstate = FREE;
         bus.req_wen[e.id] = 1'b0;
         bus.req_ren[e.id] = 1'b0;
      end
   endtask

   // Pointer at 3 after test_write_arb: all four reading gives 0,1,2,3,0.
   task automatic test_round_robin;
      exp_t e;
      bit ok;
      logic [N-1:0] ew;
      bus.mode = 1'b0;
      for (int i = 0; i < N; i++) bus.req_addr[i] = 32'h1000 + 32'(i) * 32'h100;
      foreach (exp_q[i]) exp_q.delete(i);
      exp_q.push_back('{0, 32'hCAFE0000});
      exp_q.push_back('{1, 32'hCAFE0001});
      exp_q.push_back('{2, 32'hCAFE0002});
      exp_q.push_back('{3, 32'hCAFE0003});
      exp_q.push_back('{0, 32'hCAFE0004});
      bus.req_ren = '1;
      for (int k = 0; k < 5; k++) begin
         wait_grant(ok);
         e = exp_q.pop_front();
         ew = '1; ew[e.id] = 1'b0;
         n_vec++; if (!ok || bus.grant_id !== 2'(e.id)) begin n_err++;
            $display("FAIL rr_order[%0d]: got ok%b id %0d want id %0d", k, ok, bus.grant_id, e.id); end
         n_vec++; if (bus.ramaddr !== 32'h1000 + 32'(e.id) * 32'h100) begin n_err++;
            $display("FAIL rr_addr[%0d]: got %h want %h", k, bus.ramaddr, 32'h1000 + 32'(e.id) * 32'h100); end
         bus.ramload  = e.load;
         bus.ramstate = ACCESS;
         #1;
         n_vec++; if ({bus.req_wait, bus.req_load} !== {ew, e.load}) begin n_err++;
            $display("FAIL rr_done[%0d]: got wait %h load %h want %h %h", k, bus.req_wait, bus.req_load, ew, e.load); end
         @(negedge CLK);
         bus.ramstate = FREE;
      end
   endtask

   // Entered in RELEASE with all requesters still reading.
   task automatic test_fixed_priority;
      exp_t e;
      bit ok;
      bus.mode = 1'b1;
      for (int k = 0; k < 3; k++) exp_q.push_back('{0, 32'hF00D0000 + 32'(k)});
      for (int k = 0; k < 3; k++) begin
         wait_grant(ok);
         e = exp_q.pop_front();
         n_vec++; if (!ok || bus.grant_id !== 2'(e.id)) begin n_err++;
            $display("FAIL fixed_order[%0d]: got ok%b id %0d want id %0d", k, ok, bus.grant_id, e.id); end
         bus.ramload  = e.load;
         bus.ramstate = ACCESS;
         #1;
         n_vec++; if (bus.req_load !== e.load) begin n_err++; $display("FAIL fixed_load[%0d]: got %h want %h", k, bus.req_load, e.load); end
         @(negedge CLK);
         bus.ramstate = FREE;
      end
      bus.req_ren = '0;
      bus.mode    = 1'b0;
      @(negedge CLK);
   endtask

   // Pointer at 0; requesters 1 and 2 read while RAM stays BUSY.
   task automatic test_watchdog;
      exp_t e;
      bit ok;
      logic [N-1:0] ew;
      exp_q.push_back('{1, 32'h0});
      exp_q.push_back('{2, 32'h0});
      bus.ramstate   = BUSY;
      bus.req_ren[1] = 1'b1;
      bus.req_ren[2] = 1'b1;
      wait_grant(ok);
      e = exp_q.pop_front();
      n_vec++; if (!ok || bus.grant_id !== 2'(e.id)) begin n_err++;
         $display("FAIL wdog_grant: got ok%b id %0d want id %0d", ok, bus.grant_id, e.id); end
      for (int c = 1; c <= 4; c++) begin
         n_vec++; if (bus.timeout !== (c == 4)) begin n_err++;
            $display("FAIL wdog_pulse[cycle %0d]: got %b want %b", c, bus.timeout, (c == 4)); end
         n_vec++; if ({bus.req_wait, bus.grant_valid} !== {4'hF, 1'b1}) begin n_err++;
            $display("FAIL wdog_hold[cycle %0d]: got wait %h gv %b want f 1", c, bus.req_wait, bus.grant_valid); end
         if (c < 4) @(negedge CLK);
      end
      @(negedge CLK);                    // RELEASE
      n_vec++; if ({bus.grant_valid, bus.timeout} !== 2'b00) begin n_err++;
         $display("FAIL wdog_release: got gv%b to%b want 00", bus.grant_valid, bus.timeout); end
      wait_grant(ok);
      e = exp_q.pop_front();
      ew = '1; ew[e.id] = 1'b0;
      n_vec++; if (!ok || bus.grant_id !== 2'(e.id)) begin n_err++;
         $display("FAIL wdog_next: got ok%b id %0d want id %0d", ok, bus.grant_id, e.id); end
      bus.ramstate = ACCESS;
      #1;
      n_vec++; if (bus.req_wait !== ew) begin n_err++; $display("FAIL wdog_next_done: got %h want %h", bus.req_wait, ew); end
      @(negedge CLK);
      bus.ramstate = FREE;
      bus.req_ren  = '0;
      @(negedge CLK);
   endtask

   // Pointer at 2. After the abort it must still be 2, so with 0 and 1
   // both requesting, 0 (not 1) wins.
   task automatic test_abort_reset;
      exp_t e;
      bit ok;
      exp_q.push_back('{0, 32'h0});
      exp_q.push_back('{0, 32'h0});
      bus.ramstate    = BUSY;
      bus.req_addr[0] = 32'h10;
      bus.req_ren[0]  = 1'b1;
      wait_grant(ok);
      e = exp_q.pop_front();
      n_vec++; if (!ok || {bus.grant_id, bus.ramREN} !== {2'(e.id), 1'b1}) begin n_err++;
         $display("FAIL abort_grant: got ok%b id %0d ren %b want id %0d ren 1", ok, bus.grant_id, bus.ramREN, e.id); end
      bus.req_ren[0] = 1'b0;
      #1;
      n_vec++; if ({bus.ramREN, bus.ramWEN, bus.req_wait} !== {2'b00, 4'hF}) begin n_err++;
         $display("FAIL abort_drop: got ren%b wen%b wait %h want 0 0 f", bus.ramREN, bus.ramWEN, bus.req_wait); end
      @(negedge CLK);
      n_vec++; if (bus.grant_valid !== 1'b0) begin n_err++; $display("FAIL abort_idle: got gv %b want 0", bus.grant_valid); end
      bus.req_ren[0] = 1'b1;
      bus.req_ren[1] = 1'b1;
      wait_grant(ok);
      e = exp_q.pop_front();
      n_vec++; if (!ok || bus.grant_id !== 2'(e.id)) begin n_err++;
         $display("FAIL abort_ptr: got ok%b id %0d want id %0d", ok, bus.grant_id, e.id); end
      #2;
      RST = 1'b1;
      #1;
      n_vec++; if ({bus.ramREN, bus.grant_valid, bus.req_wait, bus.ramaddr, bus.timeout} !== {2'b00, 4'hF, 32'h0, 1'b0}) begin n_err++;
         $display("FAIL rst_mid_grant: ren %b gv %b wait %h addr %h to %b want 0 0 f 0 0", bus.ramREN, bus.grant_valid, bus.req_wait, bus.ramaddr, bus.timeout); end
      @(negedge CLK);
      RST          = 1'b0;
      bus.req_ren  = '0;
      bus.ramstate = FREE;
      @(negedge CLK);
   endtask

   initial begin
      bus.mode      = 1'b0;
      bus.req_ren   = '0;
      bus.req_wen   = '0;
      bus.req_addr  = '0;
      bus.req_store = '0;
      bus.ramload   = '0;
      bus.ramstate  = FREE;
      test_reset();
      test_single();
      test_write_arb();
      test_round_robin();
      test_fixed_priority();
      test_watchdog();
      test_abort_reset();
      n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single RAM port between NREQ requesters (instruction and data sides of each CPU), one transaction at a time.
- Selection is round-robin or fixed priority; the grant is held until RAM reports ACCESS.
- A per-grant watchdog releases a RAM access that stalls.
- Sits between the coherence/cache control layer and the RAM model, replacing ad-hoc priority arbitration.

Parameters:
NREQ, 4, number of requesters; index 2c = dcache of CPU c, 2c+1 = icache of CPU c
TIMEOUT, 255, max cycles in GRANT without ACCESS before forced release (>=1)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins); sampled only in IDLE
req_ren  in  NREQ  read request per requester
req_wen  in  NREQ  write request per requester
req_addr  in  NREQ*32  word_t address per requester, packed, requester i at [32i+31:32i]
req_store  in  NREQ*32  word_t write data per requester, packed
req_wait  out  NREQ  1 = requester must hold; 0 for exactly one cycle = transaction complete
req_load  out  32  read data; valid only while the granted req_wait bit is 0
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR
grant_valid  out  1  a grant is held (state GRANT)
grant_id  out  $clog2(NREQ)  index of held grant
timeout  out  1  one-cycle pulse on watchdog release

Behaviour:
- Reset (RST high, async):
  - state=IDLE, ptr=NREQ-1, gnt=0, wdog=0.
  - All outputs 0 except req_wait = all ones.
- req[i] = req_ren[i] | req_wen[i].
- If both ren and wen are asserted for a requester, the transaction is a write (wen wins).
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - No RAM enables; req_wait all 1.
  - If any req: gnt <= winner; wdog <= 0; next state GRANT.
  - Round-robin winner: first requesting index in order ptr+1, ptr+2, ... wrapping mod NREQ, ending at ptr.
  - Fixed-priority winner: lowest requesting index.
  - Grant latency: 1 cycle from request to RAM enable.
- GRANT (combinational outputs from gnt):
  - ramaddr = req_addr[gnt]; ramstore = req_store[gnt].
  - ramWEN = req_wen[gnt]; ramREN = req_ren[gnt] & ~req_wen[gnt].
  - Other requesters' req_wait stay 1.
  - ramstate==ACCESS: req_wait[gnt]=0 and req_load=ramload this cycle; next RELEASE; ptr <= gnt.
  - req[gnt] drops before ACCESS (abort): RAM enables fall the same cycle; next IDLE; ptr unchanged; no wait pulse.
  - wdog reaches TIMEOUT-1 without ACCESS: next RELEASE; timeout=1 that cycle; ptr <= gnt; req_wait[gnt] stays 1.
  - BUSY, FREE and ERROR all hold; wdog increments, saturating. Width = $clog2(TIMEOUT+1).
  - ACCESS takes precedence over timeout in the same cycle.
- RELEASE:
  - One bubble cycle: RAM enables 0, req_wait all 1, next IDLE.
  - Gives the requester time to drop or change its request.
  - Back-to-back requests from the same requester re-arbitrate; round-robin then favours others.
- grant_valid=1 and grant_id=gnt only in GRANT; grant_id=0 otherwise.
- req_load=0 whenever no req_wait bit is 0.
- Request changes while not granted have no effect until IDLE.
- RST asserted mid-GRANT: RAM enables drop immediately (async); no completion pulse.

Decomposition:
- cpu_types_pkg, already shared, supplies word_t and ramstate_t (FREE, BUSY, ACCESS, ERROR).
- Add arb_state_t {IDLE, GRANT, RELEASE} to cpu_types_pkg.
- One sub-module, rr_pick: combinational, inputs req, ptr and mode; outputs winner index and any.

Test Plan:
- Single request, RAM answers ACCESS on the 2nd GRANT cycle:
  - Stimulus: req_ren[1]=1, addr 0x40, ramload 0xDEADBEEF.
  - Response: ramREN and ramaddr=0x40 one cycle after request; req_wait[1]=0 with req_load=0xDEADBEEF for exactly 1 cycle; then RELEASE, then IDLE.
- All 4 requesters hold reads, mode=0, RAM answers ACCESS every cycle:
  - Required grant order: 0,1,2,3,0.
  - With mode=1 the order is 0,0,0 while req0 holds.
- Write arbitration:
  - Stimulus: req_wen[2]=1, addr 0x80, store 0x12345678, with req_ren[3]=1 simultaneously, ptr=1.
  - Response: gnt=2 first; ramWEN=1 and ramstore=0x12345678; requester 3 granted after RELEASE.
- Watchdog:
  - Stimulus: TIMEOUT=4, ramstate held BUSY.
  - Response: timeout pulse on the 4th GRANT cycle; req_wait[gnt] never 0; next grant goes to the next requester.
- Abort and reset:
  - req_ren[0] drops in GRANT before ACCESS: RAM enables 0 the same cycle; IDLE next; ptr unchanged.
  - RST pulsed mid-GRANT: all outputs return to reset values immediately.
